// File: rtl/mgmt_smbus_echo_en.sv
// mgmt_smbus_echo_en
//
// SMBus target that echoes management-channel traffic. When echo_en is high at
// the address phase, write bytes sent to TARGET_ADDR go into a small buffer.
// A later read of TARGET_ADDR returns those bytes in order. Once the stored
// bytes run out, the read returns 8'hFF. When the block is disabled or
// unaddressed it NACKs and stays off the bus.
//
// Ports
//   clk         system clock, at least 20x the SCL frequency
//   reset_n     synchronous active-low reset
//   echo_en     1 = answer TARGET_ADDR, 0 = NACK everything
//   scl_in      bus SCL (asynchronous)
//   sda_in      bus SDA (asynchronous)
//   sda_oe      1 = pull SDA low (open drain)
//   busy        high from START until STOP
//   byte_count  number of bytes currently held in the echo buffer
//   overflow    sticky; a write byte arrived while the buffer was full
//   txn_done    one-cycle pulse on STOP after an addressed transaction

module mgmt_smbus_echo_en #(
  parameter logic [6:0]  TARGET_ADDR = 7'h2C,
  parameter int unsigned BUF_DEPTH   = 8,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       echo_en,
  input  logic                       scl_in,
  input  logic                       sda_in,
  output logic                       sda_oe,
  output logic                       busy,
  output logic [$clog2(BUF_DEPTH):0] byte_count,
  output logic                       overflow,
  output logic                       txn_done
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned FltW = $clog2(FILTER_LEN) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrByte,
    StWrAck,
    StRdByte,
    StRdAck,
    StIgnore
  } state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning: index 0 is SCL, index 1 is SDA.
  // The filtered value only follows the synchronized input after the input
  // has differed from it for FILTER_LEN consecutive cycles.
  // ---------------------------------------------------------------------------
  logic [1:0]      meta_q;
  logic [1:0]      sync_q;
  logic [1:0]      filt_q;
  logic [1:0]      filt_prev_q;
  logic [FltW-1:0] flt_cnt_q [2];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // The idle bus level is high on both lines.
      meta_q       <= 2'b11;
      sync_q       <= 2'b11;
      filt_q       <= 2'b11;
      filt_prev_q  <= 2'b11;
      flt_cnt_q[0] <= '0;
      flt_cnt_q[1] <= '0;
    end else begin
      meta_q      <= {sda_in, scl_in};
      sync_q      <= meta_q;
      filt_prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == filt_q[i]) begin
          flt_cnt_q[i] <= '0;
        end else if (flt_cnt_q[i] == FltW'(FILTER_LEN - 1)) begin
          filt_q[i]    <= sync_q[i];
          flt_cnt_q[i] <= '0;
        end else begin
          flt_cnt_q[i] <= flt_cnt_q[i] + FltW'(1);
        end
      end
    end
  end

  logic scl_f;
  logic sda_f;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  assign scl_f     = filt_q[0];
  assign sda_f     = filt_q[1];
  assign scl_rise  = scl_f & ~filt_prev_q[0];
  assign scl_fall  = ~scl_f & filt_prev_q[0];
  // SDA may change while SCL is high only as a START or a STOP.
  assign start_det = scl_f & filt_prev_q[0] & filt_prev_q[1] & ~sda_f;
  assign stop_det  = scl_f & filt_prev_q[0] & ~filt_prev_q[1] & sda_f;

  // ---------------------------------------------------------------------------
  // Protocol state
  // ---------------------------------------------------------------------------
  state_e          state_q;
  logic [2:0]      bit_cnt_q;
  logic [6:0]      shift_q;    // the last seven bits sampled; the eighth comes from sda_f
  logic [6:0]      tx_q;       // bits of the read byte not yet driven
  logic            ack_phase_q;
  logic            ack_q;      // our answer to the current write byte
  logic            host_ack_q; // the controller's answer to the current read byte
  logic            rd_mode_q;
  logic            matched_q;
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] rptr_q;
  logic            overflow_q;
  logic            sda_oe_q;
  logic            busy_q;
  logic            txn_done_q;

  logic [7:0]      mem [BUF_DEPTH];
  logic [7:0]      rd_byte;
  logic [7:0]      wr_data;
  logic            addr_match;
  logic            buf_full;
  logic            wr_fire;

  assign wr_data    = {shift_q, sda_f};
  assign addr_match = (shift_q == TARGET_ADDR) && echo_en;
  assign buf_full   = (count_q >= CntW'(BUF_DEPTH));
  assign rd_byte    = (rptr_q < count_q) ? mem[rptr_q[PtrW-1:0]] : 8'hFF;
  assign wr_fire    = (state_q == StWrByte) && scl_rise && (bit_cnt_q == 3'd7) &&
                      !buf_full && !start_det && !stop_det;

  // The byte count doubles as the write pointer because the two are always
  // cleared together.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[count_q[PtrW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      ack_phase_q <= 1'b0;
      ack_q       <= 1'b0;
      host_ack_q  <= 1'b0;
      rd_mode_q   <= 1'b0;
      matched_q   <= 1'b0;
      count_q     <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      txn_done_q  <= 1'b0;
    end else begin
      txn_done_q <= 1'b0;
      if (stop_det) begin
        state_q    <= StIdle;
        sda_oe_q   <= 1'b0;
        busy_q     <= 1'b0;
        txn_done_q <= matched_q;
        matched_q  <= 1'b0;
      end else if (start_det) begin
        // A repeated START keeps matched_q, so write-Sr-read gives one txn_done.
        state_q   <= StAddr;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle, StIgnore: begin
          end

          StAddr: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[5:0], sda_f};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (addr_match) begin
                  matched_q   <= 1'b1;
                  rd_mode_q   <= sda_f;
                  ack_phase_q <= 1'b0;
                  state_q     <= StAddrAck;
                  if (sda_f) begin
                    rptr_q <= '0;
                  end else begin
                    count_q <= '0;
                  end
                end else begin
                  state_q <= StIgnore;
                end
              end
            end
          end

          // The first SCL fall starts the ACK and the second fall ends it.
          StAddrAck: begin
            if (scl_fall) begin
              if (!ack_phase_q) begin
                sda_oe_q    <= 1'b1;
                ack_phase_q <= 1'b1;
              end else if (rd_mode_q) begin
                tx_q      <= rd_byte[6:0];
                sda_oe_q  <= ~rd_byte[7];
                bit_cnt_q <= '0;
                if (rptr_q < count_q) begin
                  rptr_q <= rptr_q + CntW'(1);
                end
                state_q <= StRdByte;
              end else begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= StWrByte;
              end
            end
          end

          StWrByte: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[5:0], sda_f};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ack_phase_q <= 1'b0;
                state_q     <= StWrAck;
                if (!buf_full) begin
                  count_q <= count_q + CntW'(1);
                  ack_q   <= 1'b1;
                end else begin
                  overflow_q <= 1'b1;
                  ack_q      <= 1'b0;
                end
              end
            end
          end

          StWrAck: begin
            if (scl_fall) begin
              if (!ack_phase_q) begin
                sda_oe_q    <= ack_q;
                ack_phase_q <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= StWrByte;
              end
            end
          end

          StRdByte: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ack_phase_q <= 1'b0;
                state_q     <= StRdAck;
              end
            end else if (scl_fall) begin
              tx_q     <= {tx_q[5:0], 1'b1};
              sda_oe_q <= ~tx_q[6];
            end
          end

          StRdAck: begin
            if (scl_fall) begin
              if (!ack_phase_q) begin
                sda_oe_q    <= 1'b0;
                ack_phase_q <= 1'b1;
              end else if (host_ack_q) begin
                tx_q      <= rd_byte[6:0];
                sda_oe_q  <= ~rd_byte[7];
                bit_cnt_q <= '0;
                if (rptr_q < count_q) begin
                  rptr_q <= rptr_q + CntW'(1);
                end
                state_q <= StRdByte;
              end else begin
                state_q <= StIgnore;
              end
            end else if (scl_rise && ack_phase_q) begin
              host_ack_q <= ~sda_f;
            end
          end

          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign byte_count = count_q;
  assign overflow   = overflow_q;
  assign txn_done   = txn_done_q;

endmodule

// File: tb/tb_mgmt_smbus_echo_en.sv
// Bench for mgmt_smbus_echo_en. A bus-controller model drives SCL and SDA,
// and the bench wires SDA as an open-drain AND. A reference buffer model
// predicts every ACK, byte count and overflow flag. Expected read data is
// queued when each read is issued and popped as each byte returns.

module tb_mgmt_smbus_echo_en;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       echo_en = 1'b1;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_oe;
  logic       busy;
  logic [3:0] byte_count;
  logic       overflow;
  logic       txn_done;
  logic       sda_bus;

  assign sda_bus = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  mgmt_smbus_echo_en #(
    .TARGET_ADDR (7'h2C),
    .BUF_DEPTH   (8),
    .FILTER_LEN  (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .echo_en    (echo_en),
    .scl_in     (scl_drv),
    .sda_in     (sda_bus),
    .sda_oe     (sda_oe),
    .busy       (busy),
    .byte_count (byte_count),
    .overflow   (overflow),
    .txn_done   (txn_done)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  logic [7:0] model [$];
  logic [7:0] tx_buf [16];
  bit         exp_ovf = 1'b0;
  bit         pend_match = 1'b0;
  int         exp_txn = 0;

  // Bus monitors
  int txn_cnt = 0;
  int oe_cycles = 0;
  int oe_hi_chg = 0;
  int txn_bad = 0;
  bit mon_en = 1'b0;
  bit busy_prev = 1'b0;
  bit oe_prev = 1'b0;

  always @(posedge clk) begin
    busy_prev <= busy;
    oe_prev   <= sda_oe;
    if (txn_done) begin
      txn_cnt <= txn_cnt + 1;
      if (busy || !busy_prev) txn_bad <= txn_bad + 1;
    end
    if (sda_oe) oe_cycles <= oe_cycles + 1;
    if (mon_en && scl_drv && (sda_oe != oe_prev)) oe_hi_chg <= oe_hi_chg + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_drv = 1'b1;
    wait_q(Q);
    scl_drv = 1'b1;
    wait_q(Q);
    sda_drv = 1'b0;
    wait_q(Q);
    scl_drv = 1'b0;
    wait_q(Q);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0;
    wait_q(Q);
    scl_drv = 1'b1;
    wait_q(Q);
    sda_drv = 1'b1;
    wait_q(2 * Q);
    if (pend_match) exp_txn++;
    pend_match = 1'b0;
  endtask

  task automatic bus_bit(input logic b, output logic seen);
    sda_drv = b;
    wait_q(Q);
    scl_drv = 1'b1;
    wait_q(Q);
    seen = sda_bus;
    wait_q(Q);
    scl_drv = 1'b0;
    wait_q(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(nack, s);
  endtask

  task automatic write_txn(input logic [6:0] addr, input int n, input bit do_stop);
    logic ack;
    bit   match;
    bit   e;
    match = (addr == 7'h2C) && echo_en;
    bus_start();
    send_byte({addr, 1'b0}, ack);
    check_val("wr_addr_ack", ack, match);
    check_val("busy_in_txn", busy, 1);
    if (match) begin
      model.delete();
      pend_match = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      e = 1'b0;
      if (match) begin
        if (model.size() < 8) begin
          model.push_back(tx_buf[i]);
          e = 1'b1;
        end else begin
          exp_ovf = 1'b1;
        end
      end
      send_byte(tx_buf[i], ack);
      check_val("wr_data_ack", ack, e);
    end
    check_val("wr_byte_count", byte_count, model.size());
    check_val("wr_overflow", overflow, exp_ovf);
    if (do_stop) bus_stop();
  endtask

  task automatic read_txn(input logic [6:0] addr, input int n);
    logic       ack;
    logic [7:0] d;
    bit         match;
    match = (addr == 7'h2C) && echo_en;
    bus_start();
    send_byte({addr, 1'b1}, ack);
    check_val("rd_addr_ack", ack, match);
    if (match) begin
      pend_match = 1'b1;
      for (int i = 0; i < n; i++) exp_q.push_back((i < model.size()) ? model[i] : 8'hFF);
      for (int i = 0; i < n; i++) begin
        recv_byte(i == n - 1, d);
        if (exp_q.size() == 0) check_val("rd_queue_empty", 1, 0);
        else check_val("rd_data", d, exp_q.pop_front());
      end
    end
    bus_stop();
  endtask

  task automatic post_stop_checks();
    check_val("idle_busy", busy, 0);
    check_val("idle_byte_count", byte_count, model.size());
    check_val("idle_overflow", overflow, exp_ovf);
    check_val("txn_done_count", txn_cnt, exp_txn);
  endtask

  initial begin
    int   oe_before;
    logic s;
    logic ack;

    wait_q(10);
    check_val("rst_sda_oe", sda_oe, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_byte_count", byte_count, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_txn_done", txn_done, 0);
    reset_n = 1'b1;
    wait_q(2 * Q);
    mon_en = 1'b1;

    // Basic echo of three bytes
    tx_buf[0] = 8'hA5; tx_buf[1] = 8'h5A; tx_buf[2] = 8'h01;
    write_txn(7'h2C, 3, 1'b1);
    post_stop_checks();
    read_txn(7'h2C, 3);
    post_stop_checks();

    // Disabled: all NACK, nothing driven
    echo_en = 1'b0;
    oe_before = oe_cycles;
    write_txn(7'h2C, 2, 1'b1);
    check_val("dis_oe_cycles", oe_cycles - oe_before, 0);
    post_stop_checks();
    echo_en = 1'b1;

    // Overflow at the ninth byte, then read past the end
    for (int i = 0; i < 9; i++) tx_buf[i] = 8'(i);
    write_txn(7'h2C, 9, 1'b1);
    post_stop_checks();
    read_txn(7'h2C, 9);
    post_stop_checks();

    // Short buffer reads back FF past the stored bytes, and can be read twice
    tx_buf[0] = 8'h3C; tx_buf[1] = 8'hC3;
    write_txn(7'h2C, 2, 1'b1);
    read_txn(7'h2C, 4);
    read_txn(7'h2C, 2);
    post_stop_checks();

    // Wrong address goes to IGNORE and leaves the buffer alone
    oe_before = oe_cycles;
    write_txn(7'h2D, 1, 1'b1);
    check_val("wrong_addr_oe", oe_cycles - oe_before, 0);
    post_stop_checks();

    // Write then repeated START into a read
    tx_buf[0] = 8'h77;
    write_txn(7'h2C, 1, 1'b0);
    read_txn(7'h2C, 1);
    post_stop_checks();

    // Reset during the ACK of the second data byte
    tx_buf[0] = 8'h11;
    bus_start();
    send_byte({7'h2C, 1'b0}, ack);
    check_val("rst_txn_addr_ack", ack, 1);
    send_byte(tx_buf[0], ack);
    check_val("rst_txn_b0_ack", ack, 1);
    for (int i = 7; i >= 0; i--) bus_bit(1'b0, s);
    sda_drv = 1'b1;
    wait_q(Q);
    scl_drv = 1'b1;
    wait_q(Q);
    check_val("ack_before_rst", sda_bus, 0);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_val("rst_mid_sda_oe", sda_oe, 0);
    wait_q(4);
    check_val("rst_mid_byte_count", byte_count, 0);
    check_val("rst_mid_overflow", overflow, 0);
    check_val("rst_mid_busy", busy, 0);
    scl_drv = 1'b0;
    wait_q(Q);
    reset_n = 1'b1;
    model.delete();
    exp_ovf    = 1'b0;
    pend_match = 1'b0;
    wait_q(2 * Q);
    mon_en = 1'b1;

    tx_buf[0] = 8'hDE; tx_buf[1] = 8'hAD; tx_buf[2] = 8'hBE;
    write_txn(7'h2C, 3, 1'b1);
    read_txn(7'h2C, 3);
    post_stop_checks();

    check_val("sda_oe_stable_scl_high", oe_hi_chg, 0);
    check_val("txn_done_with_busy_fall", txn_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mgmt_smbus_echo_en.md
# mgmt_smbus_echo_en

SMBus target that loops management-channel traffic back to the controller. When enabled, it accepts write bytes addressed to it into a small buffer and returns the same bytes, in order, on a subsequent read. It sits on the target side of the LTPI management SMBus channel and provides loopback and link-integrity checks; when disabled it is invisible on the bus.

## Interface
- TARGET_ADDR, 7'h2C, 7-bit SMBus address the block answers to
- BUF_DEPTH, 8, echo buffer depth in bytes (power of 2, 2..256)
- FILTER_LEN, 3, glitch-filter length in clk cycles for SCL/SDA
- clk  in  1  system clock; must run at least 20× the SCL frequency
- reset_n  in  1  synchronous, active-low reset
- echo_en  in  1  1 = respond to TARGET_ADDR, 0 = NACK everything
- scl_in  in  1  bus SCL, asynchronous
- sda_in  in  1  bus SDA, asynchronous
- sda_oe  out  1  1 = pull SDA low (open drain); 0 = release
- busy  out  1  high from START until STOP
- byte_count  out  $clog2(BUF_DEPTH)+1  bytes currently stored
- overflow  out  1  sticky; a write byte arrived with the buffer full
- txn_done  out  1  one-cycle pulse on STOP after an addressed transaction

## Operation
- SCL and SDA each pass through a 2-flop synchronizer and then a FILTER_LEN-cycle stable-value filter. All edge detection uses the filtered values.
- START: filtered SDA falls while SCL is high. STOP: SDA rises while SCL is high. A repeated START is treated as a START from any state.
- States:
  - IDLE
  - ADDR: shift 8 bits, MSB first, sampled on SCL rise.
  - ADDR_ACK
  - WR_BYTE
  - WR_ACK
  - RD_BYTE
  - RD_ACK (sample controller ACK/NACK)
  - IGNORE
- Address match: upper 7 bits equal TARGET_ADDR and echo_en is 1 when the 8th bit is sampled.
  - Match: drive ACK, go to WR_BYTE (R/W=0) or RD_BYTE (R/W=1).
  - No match: NACK, go to IGNORE until the next START or STOP.
- Write address ACK clears the buffer: write pointer = 0, byte_count = 0. overflow is not cleared.
- Each write byte:
  - If byte_count < BUF_DEPTH: store it at the write pointer, increment, ACK.
  - Otherwise: discard it, set overflow, NACK.
- Read address ACK resets the read pointer to 0. The buffer is not cleared, so a read can be repeated.
- Read byte source: buffer[read pointer] while read pointer < byte_count; otherwise 8'hFF. The read pointer stops advancing at byte_count.
- After a read byte, sample the controller's 9th bit:
  - ACK: continue with RD_BYTE.
  - NACK: go to IGNORE (SDA released).
- Transmit 0 bits by asserting sda_oe; transmit 1 bits by releasing it.
- echo_en changes take effect only at the next address phase; a transaction in progress completes unaffected.
- STOP from any state: go to IDLE, release SDA, deassert busy. Pulse txn_done if the address had matched.

## Timing
- Reset values: sda_oe=0, busy=0, byte_count=0, overflow=0, txn_done=0. The buffer contents are don't-care but unreadable, since byte_count=0.
- Reset mid-transaction: sda_oe is released on the reset clock edge and the FSM goes to IDLE. After reset the block ignores the bus until the next START.
- Input latency: 2 + FILTER_LEN clk cycles from pin to filtered value.
- sda_oe changes on the clk cycle after a filtered SCL falling edge is detected, and is held stable while SCL is high.
- ACK/NACK is driven for exactly the 9th SCL low-high-low period and released on the following SCL fall.
- byte_count updates on the clk cycle after the 8th data bit's SCL rise.
- busy asserts the cycle after START detection and deasserts the cycle after STOP detection.
- txn_done is 1 cycle wide, concurrent with busy deasserting.
- No clock stretching: SCL is never driven.

## Test plan
- Write 0x2C/W with data 0xA5, 0x5A, 0x01, STOP; then read 0x2C/R for 3 bytes, NACK on the last → address and all data ACKed; read returns A5, 5A, 01; byte_count=3; txn_done pulses twice.
- echo_en=0, write 0x2C/W → address NACKed; sda_oe never asserted; byte_count stays 0; no txn_done.
- Write 9 bytes (0x00..0x08) with BUF_DEPTH=8 → first 8 ACKed, 9th NACKed; overflow=1; byte_count=8.
- Write 2 bytes, then read 4 bytes → returns b0, b1, FF, FF.
- Address 0x2D with echo_en=1 → NACK; state IGNORE; a following STOP leaves busy=0 and byte_count unchanged.
- Assert reset_n=0 during the ACK of the second data byte → sda_oe=0 on the next clk; byte_count=0; overflow=0; a fresh write/read afterwards echoes correctly.
